// File: rtl/nanci_phase_ctrl.sv
// rtl/nanci_phase_ctrl.sv - central sort/compute phase sequencer for the Nanci PE mesh
//
// Purpose: after a start request, runs ROUNDS rounds. Each round is a shearsort
// phase (SORT_PASSES passes of SQRT_N odd-even steps, SORT_CYCLES clocks per
// step) followed by COMPUTE_CYCLES clocks of compute. Then one DONE cycle.
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous active-low reset
//   i_start       start request, sampled only in IDLE
//   i_abort       synchronous abort back to IDLE, overrides i_start
//   o_phase       0 IDLE, 1 SORT, 2 COMPUTE, 3 DONE
//   o_busy        state != IDLE
//   o_cmp_en      strobe on the first cycle of every sort step
//   o_row_pass    1 = row pass (even pass index), 0 = column pass
//   o_odd_step    parity of the step index within the pass
//   o_compute_en  high for every COMPUTE cycle
//   o_round       current round index
//   o_done        one-cycle completion pulse
module nanci_phase_ctrl #(
  parameter int SQRT_N         = 4,
  parameter int SORT_PASSES    = 5,
  parameter int SORT_CYCLES    = 2,
  parameter int COMPUTE_CYCLES = 3,
  parameter int ROUNDS         = 2,
  parameter int ROUND_W        = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic               i_abort,
  output logic [1:0]         o_phase,
  output logic               o_busy,
  output logic               o_cmp_en,
  output logic               o_row_pass,
  output logic               o_odd_step,
  output logic               o_compute_en,
  output logic [ROUND_W-1:0] o_round,
  output logic               o_done
);

  localparam int MAXC   = (SORT_CYCLES > COMPUTE_CYCLES) ? SORT_CYCLES : COMPUTE_CYCLES;
  localparam int CYC_W  = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int STEP_W = (SQRT_N > 1) ? $clog2(SQRT_N) : 1;
  localparam int PASS_W = (SORT_PASSES > 1) ? $clog2(SORT_PASSES) : 1;

  localparam logic [CYC_W-1:0]   SC_LAST   = CYC_W'(SORT_CYCLES - 1);
  localparam logic [CYC_W-1:0]   CC_LAST   = CYC_W'(COMPUTE_CYCLES - 1);
  localparam logic [STEP_W-1:0]  STEP_LAST = STEP_W'(SQRT_N - 1);
  localparam logic [PASS_W-1:0]  PASS_LAST = PASS_W'(SORT_PASSES - 1);
  localparam logic [ROUND_W-1:0] RND_LAST  = ROUND_W'(ROUNDS - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SORT    = 2'd1,
    S_COMPUTE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [CYC_W-1:0]    r_cyc, w_cyc_nxt;
  logic [STEP_W-1:0]   r_step, w_step_nxt;
  logic [PASS_W-1:0]   r_pass, w_pass_nxt;
  logic [ROUND_W-1:0]  r_round, w_round_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cyc   <= '0;
      r_step  <= '0;
      r_pass  <= '0;
      r_round <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cyc   <= w_cyc_nxt;
      r_step  <= w_step_nxt;
      r_pass  <= w_pass_nxt;
      r_round <= w_round_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cyc_nxt   = r_cyc;
    w_step_nxt  = r_step;
    w_pass_nxt  = r_pass;
    w_round_nxt = r_round;
    if (i_abort) begin
      w_state_nxt = S_IDLE;
      w_cyc_nxt   = '0;
      w_step_nxt  = '0;
      w_pass_nxt  = '0;
      w_round_nxt = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            w_state_nxt = S_SORT;
            w_cyc_nxt   = '0;
            w_step_nxt  = '0;
            w_pass_nxt  = '0;
            w_round_nxt = '0;
          end
        end
        S_SORT: begin
          // Nested wrap: cycle -> step -> pass; the last pass boundary hands off to COMPUTE.
          if (r_cyc == SC_LAST) begin
            w_cyc_nxt = '0;
            if (r_step == STEP_LAST) begin
              w_step_nxt = '0;
              if (r_pass == PASS_LAST) begin
                w_pass_nxt  = '0;
                w_state_nxt = S_COMPUTE;
              end else begin
                w_pass_nxt = r_pass + PASS_W'(1);
              end
            end else begin
              w_step_nxt = r_step + STEP_W'(1);
            end
          end else begin
            w_cyc_nxt = r_cyc + CYC_W'(1);
          end
        end
        S_COMPUTE: begin
          if (r_cyc == CC_LAST) begin
            w_cyc_nxt = '0;
            if (r_round == RND_LAST) begin
              w_state_nxt = S_DONE;
            end else begin
              w_round_nxt = r_round + ROUND_W'(1);
              w_state_nxt = S_SORT;
            end
          end else begin
            w_cyc_nxt = r_cyc + CYC_W'(1);
          end
        end
        default: begin
          // DONE: round stays at ROUNDS-1 until the next start clears it.
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // Every output is a decode of registered state only.
  assign o_phase      = r_state;
  assign o_busy       = (r_state != S_IDLE);
  assign o_cmp_en     = (r_state == S_SORT) && (r_cyc == '0);
  assign o_row_pass   = ~r_pass[0];
  assign o_odd_step   = r_step[0];
  assign o_compute_en = (r_state == S_COMPUTE);
  assign o_round      = r_round;
  assign o_done       = (r_state == S_DONE);

endmodule
